// File: rtl/return_stack.sv
// Return-address LIFO for the monocycle CPU: JAL pushes PC+1 and JR pops it.
// The top of stack is combinational, so the PC mux can load it in the cycle pop is asserted.
module return_stack #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] ret_addr_in,
    output logic [ADDR_WIDTH-1:0] ret_addr_out,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);
    localparam int IDX_WIDTH = PTR_WIDTH - 1;

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  sp;
    logic [PTR_WIDTH-1:0]  sp_next;
    logic [PTR_WIDTH-1:0]  sp_dec;
    logic [IDX_WIDTH-1:0]  top_idx;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic                  wr_en;
    logic                  v_push;
    logic                  v_pop;
    logic                  set_ovf;
    logic                  set_unf;

    assign v_push  = en & push;
    assign v_pop   = en & pop;
    assign empty   = (sp == '0);
    assign full    = (sp == DEPTH_P);
    assign count   = sp;
    assign sp_dec  = sp - 1'b1;
    assign top_idx = sp_dec[IDX_WIDTH-1:0];

    assign ret_addr_out = empty ? '0 : mem[top_idx];

    // Push+pop on a non-empty stack rewrites the top in place; on an empty one it is a plain push.
    always_comb begin
        sp_next = sp;
        wr_en   = 1'b0;
        wr_idx  = sp[IDX_WIDTH-1:0];
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (v_push && v_pop) begin
            wr_en = 1'b1;
            if (empty) begin
                set_unf = 1'b1;
                sp_next = sp + 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (v_push) begin
            if (full) begin
                set_ovf = 1'b1;
            end else begin
                wr_en   = 1'b1;
                sp_next = sp + 1'b1;
            end
        end else if (v_pop) begin
            if (empty) begin
                set_unf = 1'b1;
            end else begin
                sp_next = sp_dec;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp            <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            sp <= sp_next;
            if (set_ovf) overflow_err  <= 1'b1;
            if (set_unf) underflow_err <= 1'b1;
        end
    end

    // NOTE: the array has no reset; entries at or above sp are never visible, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= ret_addr_in;
    end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed cases with literal expectations,
// then randomized traffic checked every cycle against a queue-based LIFO model.
module tb_return_stack;

    localparam int AW = 10;
    localparam int DEPTH = 16;
    localparam int PW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] ret_addr_in = '0;
    logic [AW-1:0] ret_addr_out;
    logic          empty;
    logic          full;
    logic [PW-1:0] count;
    logic          overflow_err;
    logic          underflow_err;

    int n_checks = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Behavioural model: a queue whose back is the top of stack, plus sticky flags.
    int q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    return_stack #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .push(push),
        .pop(pop),
        .ret_addr_in(ret_addr_in),
        .ret_addr_out(ret_addr_out),
        .empty(empty),
        .full(full),
        .count(count),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic pu, input logic po, input logic [AW-1:0] d);
        if (e) begin
            if (pu && po) begin
                if (q.size() == 0) begin
                    m_unf = 1'b1;
                    q.push_back(int'(d));
                end else begin
                    q[q.size()-1] = int'(d);
                end
            end else if (pu) begin
                if (q.size() == DEPTH) m_ovf = 1'b1;
                else q.push_back(int'(d));
            end else if (po) begin
                if (q.size() == 0) m_unf = 1'b1;
                else void'(q.pop_back());
            end
        end
    endtask

    // Called at a falling edge: drives inputs, lets one rising edge pass, returns at the next falling edge.
    task automatic op(input logic e, input logic pu, input logic po, input logic [AW-1:0] d);
        en = e;
        push = pu;
        pop = po;
        ret_addr_in = d;
        @(posedge clk);
        model_step(e, pu, po, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            check("cmp_count", 32'(count), 32'(q.size()));
            check("cmp_empty", 32'(empty), 32'(q.size() == 0));
            check("cmp_full", 32'(full), 32'(q.size() == DEPTH));
            check("cmp_top", 32'(ret_addr_out), (q.size() == 0) ? 32'd0 : 32'(q[q.size()-1]));
            check("cmp_ovf", 32'(overflow_err), 32'(m_ovf));
            check("cmp_unf", 32'(underflow_err), 32'(m_unf));
        end
    end

    initial begin
        logic [AW-1:0] vals [DEPTH];

        // 1: reset, idle, then reset asserted mid-cycle while a push is pending.
        reset = 1'b1;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        started = 1'b1;
        op(1'b0, 1'b0, 1'b0, '0);
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_full", 32'(full), 32'd0);
        check("idle_top", 32'(ret_addr_out), 32'd0);
        check("idle_flags", {30'd0, overflow_err, underflow_err}, 32'd0);
        op(1'b1, 1'b1, 1'b0, 10'h0AA);
        check("pre_rst_count", 32'(count), 32'd1);
        en = 1'b1;
        push = 1'b1;
        ret_addr_in = 10'h155;
        #2 reset = 1'b1;
        model_clear();
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_top", 32'(ret_addr_out), 32'd0);
        @(negedge clk);
        push = 1'b0;
        en = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_count", 32'(count), 32'd0);

        // 2: three pushes then three pops in LIFO order.
        op(1'b1, 1'b1, 1'b0, 10'h005);
        op(1'b1, 1'b1, 1'b0, 10'h012);
        op(1'b1, 1'b1, 1'b0, 10'h3FF);
        check("p3_count", 32'(count), 32'd3);
        check("pop1_top", 32'(ret_addr_out), 32'h3FF);
        op(1'b1, 1'b0, 1'b1, '0);
        check("pop2_top", 32'(ret_addr_out), 32'h012);
        op(1'b1, 1'b0, 1'b1, '0);
        check("pop3_top", 32'(ret_addr_out), 32'h005);
        op(1'b1, 1'b0, 1'b1, '0);
        check("p3_empty", 32'(empty), 32'd1);

        // 3: fill to DEPTH, overflow attempt, drain.
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = AW'(10'h100 + i * 7);
            op(1'b1, 1'b1, 1'b0, vals[i]);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        op(1'b1, 1'b1, 1'b0, 10'h2AA);
        check("ovf_flag", 32'(overflow_err), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_top", 32'(ret_addr_out), 32'(vals[DEPTH-1]));
        for (int i = DEPTH - 1; i >= 0; i--) begin
            check("drain_top", 32'(ret_addr_out), 32'(vals[i]));
            op(1'b1, 1'b0, 1'b1, '0);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        // 4: underflow is sticky through later valid traffic.
        do_reset();
        op(1'b1, 1'b0, 1'b1, '0);
        check("unf_flag", 32'(underflow_err), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        check("unf_top", 32'(ret_addr_out), 32'd0);
        op(1'b1, 1'b1, 1'b0, 10'h0AB);
        op(1'b1, 1'b0, 1'b1, '0);
        check("unf_sticky", 32'(underflow_err), 32'd1);

        // 5: simultaneous push and pop replaces the top.
        do_reset();
        op(1'b1, 1'b1, 1'b0, 10'h010);
        check("rep_before", 32'(ret_addr_out), 32'h010);
        op(1'b1, 1'b1, 1'b1, 10'h020);
        check("rep_after", 32'(ret_addr_out), 32'h020);
        check("rep_count", 32'(count), 32'd1);

        // 6: en=0 freezes the stack even with X data on the input.
        op(1'b1, 1'b1, 1'b0, 10'h033);
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 1'b0, 'x);
        for (int i = 0; i < 3; i++) op(1'b0, 1'b0, 1'b1, 'x);
        check("hold_count", 32'(count), 32'd2);
        check("hold_top", 32'(ret_addr_out), 32'h033);
        check("hold_flags", {30'd0, overflow_err, underflow_err}, 32'd0);
        op(1'b1, 1'b0, 1'b1, '0);
        check("resume_top", 32'(ret_addr_out), 32'h020);

        // Randomized traffic with phases biased toward filling or draining.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int bias;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                op($urandom_range(0, 9) != 0, r < bias, ($urandom_range(0, 99) >= bias),
                   AW'($urandom));
            end
        end

        op(1'b0, 1'b0, 1'b0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
